bg_scroll_ctrl: RTL and testbench

Sequencer for the 128×128×12-bit background texture ROM. It converts VGA pixel coordinates into scrolled, down-scaled ROM coordinates and drives the ROM enable. It advances a per-frame horizontal scroll offset under a small run/pause/stop state machine, and delays the sync and blanking signals so they line up with the ROM's registered colour output. It sits between the VGA timing generator and the background ROM. Its `scroll_px` output is shared with the sprite and pipe logic.

---
 rtl/bg_pkg.sv | 14 +
 rtl/bg_scroll_ctrl_sig_delay.sv | 33 +++
 rtl/bg_scroll_ctrl.sv | 120 ++++++++++++
 tb/tb_bg_scroll_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bg_pkg.sv
// Shared types and constants for the background scroll sequencer.
package bg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2
  } bg_state_t;

  localparam int BG_ROM_DIM_BITS = 7;
  localparam int BG_PIPE_LAT     = 3;
  localparam int BG_SCROLL_W     = 9;

endpackage

// File: rtl/bg_scroll_ctrl_sig_delay.sv
// Fixed-depth shift register with a per-bit reset value; every stage is
// exposed so callers can tap intermediate delays.
module sig_delay #(
  parameter int               DEPTH   = 3,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WIDTH-1:0]       i_d,
  output logic [WIDTH-1:0]       o_q,
  output logic [DEPTH*WIDTH-1:0] o_taps
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  always_comb begin
    o_taps = '0;
    for (int i = 0; i < DEPTH; i++) o_taps[i*WIDTH +: WIDTH] = r_stage[i];
  end

  assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/bg_scroll_ctrl.sv
// Background ROM sequencer: scrolled/down-scaled addressing, per-frame scroll
// under a run/pause/stop FSM, and sync/blank alignment with the ROM output.
module bg_scroll_ctrl
  import bg_pkg::*;
#(
  parameter int SCALE_SHIFT  = 2,
  parameter int SPEED_W      = 4,
  parameter bit SYNC_ACT_LOW = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [9:0]                 pix_x,
  input  logic [9:0]                 pix_y,
  input  logic                       video_on_in,
  input  logic                       hsync_in,
  input  logic                       vsync_in,
  input  logic                       cmd_start,
  input  logic                       cmd_pause,
  input  logic                       cmd_stop,
  input  logic [SPEED_W-1:0]         speed,
  output logic [BG_ROM_DIM_BITS-1:0] rom_x,
  output logic [BG_ROM_DIM_BITS-1:0] rom_y,
  output logic                       rom_en,
  output logic                       video_on_out,
  output logic                       hsync_out,
  output logic                       vsync_out,
  output logic [BG_SCROLL_W-1:0]     scroll_px,
  output logic [1:0]                 state
);

  localparam logic SYNC_IDLE = SYNC_ACT_LOW ? 1'b1 : 1'b0;
  localparam logic SYNC_ACT  = ~SYNC_IDLE;

  bg_state_t              r_state, w_state_nxt;
  logic [BG_SCROLL_W-1:0] r_scroll, w_scroll_nxt;
  logic                   r_vsync_prev;
  logic                   r_pend_start, r_pend_pause, r_pend_stop;
  logic                   w_fb, w_do_start, w_do_pause, w_do_stop;
  logic [9:0]             w_sum;
  logic [BG_SCROLL_W-1:0] w_x_wrap;
  logic [2:0]             w_dly_q;
  logic [3*BG_PIPE_LAT-1:0] w_taps;
  logic                   w_unused;

  assign w_fb       = (vsync_in == SYNC_ACT) && (r_vsync_prev == SYNC_IDLE);
  // A pulse coincident with the boundary counts at that boundary.
  assign w_do_start = r_pend_start | cmd_start;
  assign w_do_pause = r_pend_pause | cmd_pause;
  assign w_do_stop  = r_pend_stop  | cmd_stop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_scroll     <= '0;
      r_vsync_prev <= SYNC_IDLE;
      r_pend_start <= 1'b0;
      r_pend_pause <= 1'b0;
      r_pend_stop  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_scroll     <= w_scroll_nxt;
      r_vsync_prev <= vsync_in;
      r_pend_start <= w_fb ? 1'b0 : w_do_start;
      r_pend_pause <= w_fb ? 1'b0 : w_do_pause;
      r_pend_stop  <= w_fb ? 1'b0 : w_do_stop;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_scroll_nxt = r_scroll;
    if (w_fb) begin
      if (r_state == RUN) w_scroll_nxt = r_scroll + BG_SCROLL_W'(speed);
      if (w_do_stop) begin
        w_state_nxt  = IDLE;
        w_scroll_nxt = '0;
      end else if (w_do_pause && (r_state == RUN)) begin
        w_state_nxt = PAUSED;
      end else if (w_do_start && (r_state != RUN)) begin
        w_state_nxt = RUN;
      end
    end
  end

  assign w_sum    = pix_x + {1'b0, r_scroll};
  assign w_x_wrap = w_sum[BG_SCROLL_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_x <= '0;
      rom_y <= '0;
    end else begin
      rom_x <= BG_ROM_DIM_BITS'(w_x_wrap >> SCALE_SHIFT);
      rom_y <= BG_ROM_DIM_BITS'(pix_y[8:0] >> SCALE_SHIFT);
    end
  end

  sig_delay #(
    .DEPTH  (BG_PIPE_LAT),
    .WIDTH  (3),
    .RST_VAL({1'b0, SYNC_IDLE, SYNC_IDLE})
  ) u_sync_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({video_on_in, hsync_in, vsync_in}),
    .o_q   (w_dly_q),
    .o_taps(w_taps)
  );

  // ROM holds two register stages, so keep it enabled one cycle past the run.
  assign rom_en       = w_taps[2] | w_taps[5];
  assign video_on_out = w_dly_q[2];
  assign hsync_out    = w_dly_q[1];
  assign vsync_out    = w_dly_q[0];
  assign scroll_px    = r_scroll;
  assign state        = r_state;

  assign w_unused = &{1'b0, pix_y[9], w_sum[9], w_taps[8:6], w_taps[4:3], w_taps[1:0]};

endmodule

// File: tb/tb_bg_scroll_ctrl.sv
// Self-checking bench for bg_scroll_ctrl: scoreboard queues hold expected
// state/scroll per frame and expected delayed sync per cycle.
module tb_bg_scroll_ctrl;
  import bg_pkg::*;

  logic       clk, rst_n;
  logic [9:0] pix_x, pix_y;
  logic       video_on_in, hsync_in, vsync_in;
  logic       cmd_start, cmd_pause, cmd_stop;
  logic [3:0] speed;
  logic [6:0] rom_x, rom_y;
  logic       rom_en, video_on_out, hsync_out, vsync_out;
  logic [8:0] scroll_px;
  logic [1:0] state;

  typedef struct packed {
    logic [1:0] st;
    logic [8:0] sc;
  } exp_t;

  exp_t       exp_q[$];
  logic [2:0] sb_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  bg_scroll_ctrl dut (
    .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
    .video_on_in(video_on_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_stop(cmd_stop),
    .speed(speed), .rom_x(rom_x), .rom_y(rom_y), .rom_en(rom_en),
    .video_on_out(video_on_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .scroll_px(scroll_px), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fb();
    vsync_in = 1'b0;
    tick();
    vsync_in = 1'b1;
    tick();
  endtask

  task automatic pulse(input logic s, input logic p, input logic t);
    cmd_start = s; cmd_pause = p; cmd_stop = t;
    tick();
    cmd_start = 1'b0; cmd_pause = 1'b0; cmd_stop = 1'b0;
  endtask

  task automatic fb_and_compare(input string name);
    exp_t e;
    do_fb();
    e = exp_q.pop_front();
    n_checks++;
    if (state !== e.st) begin
      n_fail++;
      $display("FAIL %s state: got %0d expected %0d", name, state, e.st);
    end
    n_checks++;
    if (scroll_px !== e.sc) begin
      n_fail++;
      $display("FAIL %s scroll: got %0d expected %0d", name, scroll_px, e.sc);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    n_checks++;
    if ({state, scroll_px, rom_x, rom_y, rom_en, video_on_out, hsync_out, vsync_out} !==
        {2'd0, 9'd0, 7'd0, 7'd0, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL %s: got st=%0d sc=%0d rx=%0d ry=%0d en=%0d von=%0d hs=%0d vs=%0d expected 0 0 0 0 0 0 1 1",
               name, state, scroll_px, rom_x, rom_y, rom_en, video_on_out, hsync_out, vsync_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pix_x = '0; pix_y = '0;
    video_on_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    cmd_start = 1'b0; cmd_pause = 1'b0; cmd_stop = 1'b0;
    speed = '0;
    #23;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();
    tick();
    check_reset_outputs("after_release");
  endtask

  task automatic test_run();
    speed = 4'd3;
    pulse(1'b1, 1'b0, 1'b0);
    exp_q.push_back('{RUN, 9'd0});
    exp_q.push_back('{RUN, 9'd3});
    exp_q.push_back('{RUN, 9'd6});
    exp_q.push_back('{RUN, 9'd9});
    exp_q.push_back('{RUN, 9'd12});
    for (int i = 0; i < 5; i++) fb_and_compare($sformatf("run_frame%0d", i));
  endtask

  task automatic test_wrap();
    pulse(1'b0, 1'b0, 1'b1);
    exp_q.push_back('{IDLE, 9'd0});
    fb_and_compare("wrap_stop");
    pulse(1'b1, 1'b0, 1'b0);
    exp_q.push_back('{RUN, 9'd0});
    fb_and_compare("wrap_start");
    speed = 4'd15;
    repeat (33) do_fb();
    exp_q.push_back('{RUN, 9'd510});
    fb_and_compare("wrap_reach510");
    speed = 4'd5;
    exp_q.push_back('{RUN, 9'd3});
    fb_and_compare("wrap_mod512");
    pix_x = 10'd509;
    tick();
    n_checks++;
    if (rom_x !== 7'd0) begin
      n_fail++;
      $display("FAIL wrap_rom_x: got %0d expected 0", rom_x);
    end
    pix_x = 10'd0;
  endtask

  task automatic test_cmd_combo();
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    exp_q.push_back('{PAUSED, 9'd8});
    fb_and_compare("pause_over_start");
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1);
    exp_q.push_back('{IDLE, 9'd0});
    fb_and_compare("stop_over_all");
    vsync_in = 1'b0;
    cmd_start = 1'b1;
    tick();
    cmd_start = 1'b0;
    vsync_in = 1'b1;
    tick();
    n_checks++;
    if (state !== RUN) begin
      n_fail++;
      $display("FAIL start_on_fb: got %0d expected %0d", state, RUN);
    end
    exp_q.push_back('{RUN, 9'd5});
    fb_and_compare("pending_cleared");
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    exp_q.push_back('{PAUSED, 9'd10});
    fb_and_compare("pause_repeat");
    exp_q.push_back('{PAUSED, 9'd10});
    fb_and_compare("paused_holds");
  endtask

  task automatic test_mapping();
    pulse(1'b0, 1'b0, 1'b1);
    exp_q.push_back('{IDLE, 9'd0});
    fb_and_compare("map_clear");
    pix_y = 10'd479; pix_x = 10'd7;
    tick();
    n_checks++;
    if ({rom_y, rom_x} !== {7'd119, 7'd1}) begin
      n_fail++;
      $display("FAIL map_last_row: got y=%0d x=%0d expected y=119 x=1", rom_y, rom_x);
    end
    pix_y = 10'd0; pix_x = 10'd639;
    tick();
    n_checks++;
    if ({rom_y, rom_x} !== {7'd0, 7'd31}) begin
      n_fail++;
      $display("FAIL map_col639: got y=%0d x=%0d expected y=0 x=31", rom_y, rom_x);
    end
    pix_x = 10'd0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_pipeline();
    logic [2:0] got, e;
    logic       prev_von;
    sb_q.delete();
    sb_q.push_back(3'b011);
    sb_q.push_back(3'b011);
    prev_von = 1'b0;
    for (int k = 0; k < 650; k++) begin
      video_on_in = (k < 640);
      hsync_in    = (k >= 645) ? 1'b0 : 1'($urandom_range(0, 1));
      vsync_in    = (k % 97 == 50) ? 1'b0 : 1'b1;
      sb_q.push_back({video_on_in, hsync_in, vsync_in});
      tick();
      e   = sb_q.pop_front();
      got = {video_on_out, hsync_out, vsync_out};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL pipe_sync cycle %0d: got %b expected %b", k + 1, got, e);
      end
      n_checks++;
      if (rom_en !== (video_on_in | prev_von)) begin
        n_fail++;
        $display("FAIL pipe_rom_en cycle %0d: got %0d expected %0d", k + 1, rom_en, video_on_in | prev_von);
      end
      prev_von = video_on_in;
    end
    video_on_in = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_reset_midline();
    pulse(1'b1, 1'b0, 1'b0);
    exp_q.push_back('{RUN, 9'd0});
    fb_and_compare("mid_start");
    speed = 4'd10;
    repeat (9) do_fb();
    exp_q.push_back('{RUN, 9'd100});
    fb_and_compare("mid_reach100");
    video_on_in = 1'b1; pix_x = 10'd200; pix_y = 10'd100; hsync_in = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({rom_en, rom_x, rom_y} !== {1'b1, 7'd75, 7'd25}) begin
      n_fail++;
      $display("FAIL mid_active: got en=%0d x=%0d y=%0d expected 1 75 25", rom_en, rom_x, rom_y);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    tick();
    video_on_in = 1'b0; hsync_in = 1'b1; pix_x = '0; pix_y = '0;
    rst_n = 1'b1;
    exp_q.push_back('{IDLE, 9'd0});
    fb_and_compare("mid_no_autorun");
    pulse(1'b1, 1'b0, 1'b0);
    exp_q.push_back('{RUN, 9'd0});
    fb_and_compare("mid_restart");
    exp_q.push_back('{RUN, 9'd10});
    fb_and_compare("mid_resume");
  endtask

  initial begin
    test_reset();
    test_run();
    test_wrap();
    test_cmd_combo();
    test_mapping();
    test_pipeline();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
